// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one bit per cycle,
// sign fix-up in a final cycle, MTHI/MTLO writes accepted only when idle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   orig_q, orig_d;
  logic [1:0]         op_q, op_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sgn_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg, rem_neg;

  assign sgn_op = ~op[0];
  assign abs_a  = (sgn_op && opa[WIDTH-1]) ? -opa : opa;
  assign abs_b  = (sgn_op && opb[WIDTH-1]) ? -opb : opb;

  // prod_q holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = prod_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  assign div_diff = div_sh[WIDTH-1:0] - opnd_q;
  assign rem_new  = div_ge ? div_diff : div_sh[WIDTH-1:0];

  assign prod_neg = -prod_q;
  assign quo_neg  = -prod_q[WIDTH-1:0];
  assign rem_neg  = -prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    orig_d  = orig_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          op_d    = op;
          qneg_d  = opa[WIDTH-1] ^ opb[WIDTH-1];
          rneg_d  = opa[WIDTH-1];
          dz_d    = op[1] && (opb == '0);
          orig_d  = opa;
          opnd_d  = op[1] ? abs_b : abs_a;
          prod_d  = op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (op_q[1]) prod_d = {rem_new, prod_q[WIDTH-2:0], div_ge};
        else         prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = (!op_q[0] && qneg_q) ? prod_neg : prod_q;
        end else if (dz_q) begin
          hi_d = orig_q;
          lo_d = '1;
        end else begin
          lo_d = (!op_q[0] && qneg_q) ? quo_neg : prod_q[WIDTH-1:0];
          hi_d = (!op_q[0] && rneg_q) ? rem_neg : prod_q[2*WIDTH-1:WIDTH];
        end
        dbz_d   = op_q[1] && dz_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      orig_q  <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      orig_q  <= orig_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: 32-bit and 8-bit instances, directed vectors,
// expected results queued at issue and checked by monitors on done.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] opa, opb, wdata;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8, wr_hi8, wr_lo8;
  logic [1:0]  op8;
  logic [7:0]  opa8, opb8, wdata8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  ex_muldiv_unit #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  ex_muldiv_unit #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst_n), .start(start8), .op(op8), .opa(opa8), .opb(opb8),
    .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wdata(wdata8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: compare on every done pulse against the oldest queued result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb32.size() == 0) check("w32_unexpected_done", 64'd1, 64'd0);
      else begin
        e = sb32.pop_front();
        $display("[TB] w32 op#%0d done: hi=%h lo=%h dbz=%0b", e.id, hi, lo, dbz);
        check($sformatf("w32_op%0d_hi", e.id), {32'd0, hi}, {32'd0, e.hi});
        check($sformatf("w32_op%0d_lo", e.id), {32'd0, lo}, {32'd0, e.lo});
        check($sformatf("w32_op%0d_dbz", e.id), {63'd0, dbz}, {63'd0, e.dbz});
        check($sformatf("w32_op%0d_latency", e.id), 64'(cyc), 64'(e.cyc));
        check($sformatf("w32_op%0d_busy_at_done", e.id), {63'd0, busy}, 64'd0);
      end
    end else if (rst_n && dbz) begin
      check("w32_dbz_without_done", {63'd0, dbz}, 64'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      if (sb8.size() == 0) check("w8_unexpected_done", 64'd1, 64'd0);
      else begin
        e = sb8.pop_front();
        $display("[TB] w8 op#%0d done: hi=%h lo=%h dbz=%0b", e.id, hi8, lo8, dbz8);
        check($sformatf("w8_op%0d_hi", e.id), {56'd0, hi8}, {32'd0, e.hi});
        check($sformatf("w8_op%0d_lo", e.id), {56'd0, lo8}, {32'd0, e.lo});
        check($sformatf("w8_op%0d_dbz", e.id), {63'd0, dbz8}, {63'd0, e.dbz});
        check($sformatf("w8_op%0d_latency", e.id), 64'(cyc), 64'(e.cyc));
      end
    end
  end

  int next_id = 0;

  task automatic wait_empty32();
    int n = 0;
    while (sb32.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb32.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL w32_timeout: got no done, expected done within 100 cycles");
      sb32.delete();
    end
  endtask

  task automatic wait_empty8();
    int n = 0;
    while (sb8.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb8.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL w8_timeout: got no done, expected done within 50 cycles");
      sb8.delete();
    end
  endtask

  task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = cyc + 34; e.id = next_id++;
    sb32.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("w32_op%0d_busy_after_accept", e.id), {63'd0, busy}, 64'd1);
  endtask

  task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed);
    issue32(o, a, b, eh, el, ed);
    wait_empty32();
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eh, input logic [7:0] el, input logic ed);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; op8 = o; opa8 = a; opb8 = b;
    e.hi = {24'd0, eh}; e.lo = {24'd0, el}; e.dbz = ed; e.cyc = cyc + 10; e.id = next_id++;
    sb8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    wait_empty8();
  endtask

  task automatic mt32(input logic h, input logic l, input logic [31:0] d,
                      input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    wr_hi = h; wr_lo = l; wdata = d;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    $display("[TB] w32 mt hi=%0b lo=%0b data=%h -> hi=%h lo=%h", h, l, d, hi, lo);
    check("w32_mt_hi", {32'd0, hi}, {32'd0, eh});
    check("w32_mt_lo", {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; op = 2'd0; opa = '0; opb = '0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    start8 = 1'b0; op8 = 2'd0; opa8 = '0; opb8 = '0; wr_hi8 = 1'b0; wr_lo8 = 1'b0; wdata8 = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, dbz}, 64'd0);
    rst_n = 1'b1;

    mt32(1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    mt32(1'b0, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'h12345678);

    run32(2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run32(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run32(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    run32(2'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0);
    run32(2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);
    run32(2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run32(2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run32(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run32(2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
    run32(2'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1);
    run32(2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

    // Second start and MTHI/MTLO in the middle of a run must be ignored.
    mt32(1'b1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    issue32(2'd1, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'd2; opa = 32'd100; opb = 32'd7;
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    $display("[TB] w32 mid-run start+mt: hi=%h lo=%h busy=%0b", hi, lo, busy);
    check("w32_midrun_hi_held", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
    check("w32_midrun_lo_held", {32'd0, lo}, {32'd0, 32'hA5A5A5A5});
    wait_empty32();
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a run: no completion afterwards.
    @(negedge clk);
    start = 1'b1; op = 2'd1; opa = 32'd3; opb = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] w32 async reset mid-run: hi=%h lo=%h busy=%0b", hi, lo, busy);
    check("w32_rst_hi", {32'd0, hi}, 64'd0);
    check("w32_rst_lo", {32'd0, lo}, 64'd0);
    check("w32_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("w32_rst_hi_after", {32'd0, hi}, 64'd0);

    run8(2'd0, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
    @(negedge clk);
    wr_hi8 = 1'b1; wdata8 = 8'hA5;
    @(negedge clk);
    wr_hi8 = 1'b0;
    $display("[TB] w8 mthi A5: hi=%h lo=%h", hi8, lo8);
    check("w8_mthi_hi", {56'd0, hi8}, 64'h00000000000000A5);
    check("w8_mthi_lo", {56'd0, lo8}, 64'd0);
    run8(2'd2, 8'h81, 8'h05, 8'hFE, 8'hE7, 1'b0);
    run8(2'd3, 8'h2A, 8'h00, 8'h2A, 8'hFF, 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle EX ALU.
- Executes MIPS MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the architectural HI/LO registers.
- Also services MTHI/MTLO writes.
- The pipeline/control stalls on busy; MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; WIDTH >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
- opa  in  WIDTH  rs operand (multiplicand / dividend); sampled with start.
- opb  in  WIDTH  rt operand (multiplier / divisor); sampled with start.
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  valid with done; set when a DIV/DIVU had opb=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (RST=0, any time including mid-operation):
  - state=IDLE; hi=lo=0; busy=done=div_by_zero=0; internal accumulators and counter cleared.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On start=1 at edge E0:
    - latch op.
    - latch |opa| and |opb| (magnitude only for signed ops; raw value for unsigned ops).
    - latch result-sign flags: quotient/product negative = opa[MSB]^opb[MSB]; remainder negative = opa[MSB].
    - counter=WIDTH; busy=1 after E0; go to RUN.
- RUN:
  - Exactly WIDTH edges, counter decrements once per edge.
  - Multiply: shift-add of a 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - When counter reaches 1, next state is FIX.
- FIX (edge E0+WIDTH+1):
  - Apply two's-complement negation per the latched sign flags (signed ops only).
  - Write hi/lo.
  - busy=0, done=1 for exactly one cycle; return to IDLE.
  - Result is visible on hi/lo in the same cycle done is high.
  - Total latency: done is high during the cycle after edge WIDTH+1 from accept (33 for WIDTH=32).
- Multiply result: {hi,lo} = full 2*WIDTH product.
- Divide result: lo = quotient, truncated toward zero; hi = remainder, with the same sign as the dividend.
- Divide by zero (DIV or DIVU with opb=0):
  - Full latency is still taken.
  - Result: lo = all ones; hi = opa, unmodified original value.
  - div_by_zero=1 in the done cycle, otherwise 0.
- Signed overflow (DIV, opa=MIN, opb=-1): lo=MIN, hi=0; no flag.
- Start while busy: ignored; no queueing, no effect on the running operation.
- wr_hi/wr_lo:
  - In IDLE: write wdata to hi/lo at the next edge; both strobes together write both registers.
  - While busy (RUN/FIX): ignored.
- start together with wr_hi/wr_lo in IDLE: the write takes effect now; the completion later overwrites hi/lo.
- hi/lo hold their value in all other cycles; they are not disturbed during RUN.

Test Plan:
1. WIDTH=32, MULT opa=0xFFFFFFFD (-3), opb=5 -> done one cycle after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for edges 1..33.
2. MULTU opa=opb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT with the same operands -> hi=0, lo=1.
3. DIV opa=-7, opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV opa=0x80000000, opb=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
4. DIVU opa=7, opb=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1 in the done cycle only.
5. Mid-operation and handshake checks:
   - Second start and wr_lo=1 (wdata=0x1234) at RUN cycle 10 -> both ignored; first result unchanged.
   - RST low at RUN cycle 5 -> hi=lo=0, busy=0 immediately; no done pulse.
6. WIDTH=8 instance:
   - MULT 0x80 * 0x80 -> hi=0x40, lo=0x00, done one cycle after edge 9.
   - MTHI 0xA5 in IDLE -> hi=0xA5 next cycle, lo unchanged.
